// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
// Direction and boundary-policy encodings plus the Gray-code conversion.
package counter_pkg;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;
  localparam logic POL_WRAP  = 1'b0;
  localparam logic POL_SAT   = 1'b1;

  // Callers zero-extend to 16 bits and truncate the result back to their width.
  function automatic logic [15:0] bin2gray(input logic [15:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/param_updown_counter_if.sv
// Control/status bundle between the counter and its user.
// The qc_gray member exists only when PARAM_UPDOWN_COUNTER_GRAY_EN is defined.
interface param_updown_counter_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             mode;
  logic             sat;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] qc;
  logic             wrap;
  logic             at_limit;
  logic             load_err;
`ifdef PARAM_UPDOWN_COUNTER_GRAY_EN
  logic [WIDTH-1:0] qc_gray;

  modport master (
    output en, mode, sat, clr, load, load_val,
    input  qc, wrap, at_limit, load_err, qc_gray
  );
  modport slave (
    input  en, mode, sat, clr, load, load_val,
    output qc, wrap, at_limit, load_err, qc_gray
  );
`else
  modport master (
    output en, mode, sat, clr, load, load_val,
    input  qc, wrap, at_limit, load_err
  );
  modport slave (
    input  en, mode, sat, clr, load, load_val,
    output qc, wrap, at_limit, load_err
  );
`endif
endinterface

// File: rtl/updown_next_state.sv
// Combinational next-count, wrap and load-error logic for the up/down counter.
// Priority per edge: clr, then load, then en, otherwise hold.
module updown_next_state
  import counter_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic [WIDTH-1:0] qc,
  input  logic             en,
  input  logic             mode,
  input  logic             sat,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] qc_d,
  output logic             wrap_d,
  output logic             load_err_d
);

  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH:0]   MOD_C  = (WIDTH + 1)'(MODULUS);

  logic load_in_range_s;

  // One extra bit so MODULUS == 2**WIDTH compares correctly.
  assign load_in_range_s = ({1'b0, load_val} < MOD_C);

  // Next count and the one-cycle status flags that accompany it.
  always_comb begin
    qc_d       = qc;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (clr) begin
      qc_d = ZERO_C;
    end else if (load) begin
      if (load_in_range_s) begin
        qc_d = load_val;
      end else begin
        qc_d       = MAX_C;
        load_err_d = 1'b1;
      end
    end else if (en) begin
      case (mode)
        MODE_UP: begin
          if (qc != MAX_C) begin
            qc_d = qc + WIDTH'(1'b1);
          end else if (sat == POL_WRAP) begin
            qc_d   = ZERO_C;
            wrap_d = 1'b1;
          end else begin
            qc_d = qc;
          end
        end
        MODE_DOWN: begin
          if (qc != ZERO_C) begin
            qc_d = qc - WIDTH'(1'b1);
          end else if (sat == POL_WRAP) begin
            qc_d   = MAX_C;
            wrap_d = 1'b1;
          end else begin
            qc_d = qc;
          end
        end
        default: qc_d = qc;
      endcase
    end else begin
      qc_d = qc;
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter: registers count and pulse flags, derives at_limit.
// Optional registered Gray output enabled by PARAM_UPDOWN_COUNTER_GRAY_EN.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  param_updown_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};

  generate
    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
      $error("param_updown_counter: WIDTH must be 1..16");
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("param_updown_counter: MODULUS must be 2..2**WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] qc_d, qc_q;
  logic             wrap_d, wrap_q;
  logic             load_err_d, load_err_q;

  updown_next_state #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .qc         (qc_q),
    .en         (bus.en),
    .mode       (bus.mode),
    .sat        (bus.sat),
    .clr        (bus.clr),
    .load       (bus.load),
    .load_val   (bus.load_val),
    .qc_d       (qc_d),
    .wrap_d     (wrap_d),
    .load_err_d (load_err_d)
  );

  // Count and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      qc_q       <= ZERO_C;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      qc_q       <= qc_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.qc       = qc_q;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = load_err_q;
  // Follows mode combinationally so a direction change is visible immediately.
  assign bus.at_limit = (bus.mode == MODE_DOWN) ? (qc_q == ZERO_C) : (qc_q == MAX_C);

`ifdef PARAM_UPDOWN_COUNTER_GRAY_EN
  generate
    if (MODULUS != (1 << WIDTH)) begin : g_bad_gray
      $error("param_updown_counter: Gray output needs MODULUS == 2**WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] qc_gray_d, qc_gray_q;

  assign qc_gray_d = WIDTH'(bin2gray(16'(qc_d)));

  // Gray register updates on the same edge as qc.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      qc_gray_q <= ZERO_C;
    end else begin
      qc_gray_q <= qc_gray_d;
    end
  end

  assign bus.qc_gray = qc_gray_q;
`endif

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: MODULUS=8 and MODULUS=6 instances, table-driven
// vectors through an expected-result queue plus hand-written corner sequences.
module tb_param_updown_counter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  param_updown_counter_if #(.WIDTH(3)) if8 ();
  param_updown_counter_if #(.WIDTH(3)) if6 ();

  param_updown_counter #(.WIDTH(3), .MODULUS(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (if8)
  );

  param_updown_counter #(.WIDTH(3), .MODULUS(6)) dut6 (
    .clk   (clk),
    .reset (reset),
    .bus   (if6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         sel;
    logic       en, mode, sat, clr, load;
    logic [2:0] lv;
    logic [2:0] qc;
    logic       wrap, lerr, atl;
  } vec_t;

  typedef struct {
    int         sel;
    int         idx;
    logic [2:0] qc;
    logic       wrap, lerr, atl;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];

  task automatic check(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input int sel, input logic en, input logic mode, input logic sat,
                     input logic clr, input logic load, input logic [2:0] lv,
                     input logic [2:0] qc, input logic wrap, input logic lerr, input logic atl);
    vec_t v;
    v.sel = sel; v.en = en; v.mode = mode; v.sat = sat; v.clr = clr; v.load = load;
    v.lv = lv; v.qc = qc; v.wrap = wrap; v.lerr = lerr; v.atl = atl;
    tbl.push_back(v);
  endtask

  task automatic step(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    @(negedge clk);
    if (v.sel == 8) begin
      if8.en = v.en; if8.mode = v.mode; if8.sat = v.sat;
      if8.clr = v.clr; if8.load = v.load; if8.load_val = v.lv;
      if6.en = 1'b0; if6.clr = 1'b0; if6.load = 1'b0;
    end else begin
      if6.en = v.en; if6.mode = v.mode; if6.sat = v.sat;
      if6.clr = v.clr; if6.load = v.load; if6.load_val = v.lv;
      if8.en = 1'b0; if8.clr = 1'b0; if8.load = 1'b0;
    end
    e.sel = v.sel; e.idx = idx; e.qc = v.qc; e.wrap = v.wrap; e.lerr = v.lerr; e.atl = v.atl;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    if (got.sel == 8) begin
      check("qc8", got.idx, 16'(if8.qc), 16'(got.qc));
      check("wrap8", got.idx, 16'(if8.wrap), 16'(got.wrap));
      check("load_err8", got.idx, 16'(if8.load_err), 16'(got.lerr));
      check("at_limit8", got.idx, 16'(if8.at_limit), 16'(got.atl));
    end else begin
      check("qc6", got.idx, 16'(if6.qc), 16'(got.qc));
      check("wrap6", got.idx, 16'(if6.wrap), 16'(got.wrap));
      check("load_err6", got.idx, 16'(if6.load_err), 16'(got.lerr));
      check("at_limit6", got.idx, 16'(if6.at_limit), 16'(got.atl));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    if8.en = 1'b0; if8.mode = 1'b0; if8.sat = 1'b0; if8.clr = 1'b0; if8.load = 1'b0; if8.load_val = 3'd0;
    if6.en = 1'b0; if6.mode = 1'b1; if6.sat = 1'b0; if6.clr = 1'b0; if6.load = 1'b0; if6.load_val = 3'd0;

    // sel en mode sat clr load lv | qc wrap lerr atl
    for (int i = 1; i <= 7; i++)
      add(8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'(i), 1'b0, 1'b0, (i == 7) ? 1'b1 : 1'b0);
    add(8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    add(8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0);
    add(8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd2, 1'b0, 1'b0, 1'b0);
    add(8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++)
      add(8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, (i >= 7) ? 3'd7 : 3'(i), 1'b0, 1'b0, (i >= 7) ? 1'b1 : 1'b0);
    add(8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd6, 1'b0, 1'b0, 1'b0);
    add(8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0);
    add(8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0);
    add(8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 3'd7, 1'b0, 1'b0, 1'b1);
    add(8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 3'd2, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      add(8, 1'b0, 1'(i % 2), 1'b0, 1'b0, 1'b0, 3'd0, 3'd2, 1'b0, 1'b0, 1'b0);
    add(8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    add(8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    add(8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    add(8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd7, 1'b1, 1'b0, 1'b0);
    add(8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd6, 1'b0, 1'b0, 1'b0);
    // MODULUS = 6
    for (int i = 5; i >= 0; i--)
      add(6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'(i), (i == 5) ? 1'b1 : 1'b0, 1'b0, (i == 0) ? 1'b1 : 1'b0);
    add(6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd5, 1'b1, 1'b0, 1'b0);
    add(6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 3'd5, 1'b0, 1'b1, 1'b0);
    add(6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd5, 1'b0, 1'b0, 1'b0);
    add(6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 3'd5, 1'b0, 1'b1, 1'b1);
    add(6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 3'd5, 1'b0, 1'b0, 1'b1);
    add(6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    add(6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    add(6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0);

    // Reset state while reset is still asserted.
    #8;
    check("reset_qc8", 0, 16'(if8.qc), 16'd0);
    check("reset_wrap8", 0, 16'(if8.wrap), 16'd0);
    check("reset_lerr8", 0, 16'(if8.load_err), 16'd0);
    check("reset_atl8", 0, 16'(if8.at_limit), 16'd0);
    check("reset_qc6", 0, 16'(if6.qc), 16'd0);
    check("reset_atl6", 0, 16'(if6.at_limit), 16'd1);
    #2;
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // at_limit follows a mode change without a clock edge.
    v.sel = 8; v.en = 1'b0; v.mode = 1'b0; v.sat = 1'b0; v.clr = 1'b0; v.load = 1'b1;
    v.lv = 3'd7; v.qc = 3'd7; v.wrap = 1'b0; v.lerr = 1'b0; v.atl = 1'b1;
    step(v, 100);
    if8.load = 1'b0;
    if8.mode = 1'b1;
    #1;
    check("atl_mode_down", 101, 16'(if8.at_limit), 16'd0);
    if8.mode = 1'b0;
    #1;
    check("atl_mode_up", 102, 16'(if8.at_limit), 16'd1);

    // Asynchronous reset mid-count clears between edges.
    v.lv = 3'd4; v.qc = 3'd4; v.atl = 1'b0;
    step(v, 103);
    @(negedge clk);
    if8.load = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async_qc8", 104, 16'(if8.qc), 16'd0);
    check("async_wrap8", 104, 16'(if8.wrap), 16'd0);
    check("async_lerr8", 104, 16'(if8.load_err), 16'd0);
    check("async_qc6", 104, 16'(if6.qc), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    v.en = 1'b1; v.load = 1'b0; v.lv = 3'd0; v.qc = 3'd1;
    step(v, 105);

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
Parametrised synchronous up/down counter. It generalises the 3-bit T-flip-flop up/down counter in three ways: configurable width and modulus, wrap or saturate policy, and synchronous clear, load and enable controls.
Provides registered wrap and saturation status for timers, address generators and modulo sequencers.
Single clock domain.

Parameters:
WIDTH, 3, counter register width in bits (1 to 16).
MODULUS, 8, count range 0..MODULUS-1; legal range 2 to 2**WIDTH; checked by elaboration-time assertion.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
en  input  1  count enable; when 0, count holds (unless clr or load)
mode  input  1  direction: 0 = up, 1 = down
sat  input  1  boundary policy: 0 = wrap, 1 = saturate
clr  input  1  synchronous clear to 0
load  input  1  synchronous parallel load
load_val  input  WIDTH  value to load
qc  output  WIDTH  current count
wrap  output  1  one-cycle pulse, asserted with the qc value produced by a wrap
at_limit  output  1  level; high while qc equals the bound in the current direction (MODULUS-1 when up, 0 when down)
load_err  output  1  one-cycle pulse; load_val was at or above MODULUS

Behaviour:
- Reset (async, active-high): qc=0, wrap=0, load_err=0. at_limit=1 if mode=1, else 0. Counting resumes on the first rising edge after reset deasserts.
- Per-edge priority: clr > load > en > hold.
- clr: qc<=0; wrap<=0; load_err<=0.
- load: qc<=load_val when load_val<MODULUS, and load_err<=0. Otherwise qc<=MODULUS-1 and load_err<=1. wrap<=0.
- en with mode=0 (up):
  - qc<MODULUS-1: qc<=qc+1.
  - qc==MODULUS-1 and sat=0: qc<=0, wrap<=1.
  - qc==MODULUS-1 and sat=1: qc holds, wrap<=0.
- en with mode=1 (down):
  - qc>0: qc<=qc-1.
  - qc==0 and sat=0: qc<=MODULUS-1, wrap<=1.
  - qc==0 and sat=1: qc holds, wrap<=0.
- wrap and load_err are registered and return to 0 on the next edge unless re-triggered. Latency is one cycle from input to qc/flags.
- at_limit is combinational from qc and mode, so it tracks a direction change in the same cycle.
- Changing mode takes effect at the next edge; no dead cycle.
- Non-power-of-2 MODULUS: qc must never hold a value >= MODULUS.
- Arithmetic is on WIDTH bits with no carry-out port. Compare against MODULUS-1 as a WIDTH-bit constant.

Optional Feature:
Macro: PARAM_UPDOWN_COUNTER_GRAY_EN
- Defined: extra output qc_gray [WIDTH-1:0], registered Gray code of the next qc, updated on the same edge as qc. Reset value is 0. Only valid when MODULUS = 2**WIDTH; an elaboration error is raised otherwise.
- Undefined: port absent; no extra logic.

Decomposition:
- Package counter_pkg holds:
  - constants MODE_UP=1'b0, MODE_DOWN=1'b1, POL_WRAP=1'b0, POL_SAT=1'b1;
  - function bin2gray.
- One natural sub-module: updown_next_state, the combinational next-count, wrap and load_err logic. Top level holds the registers and at_limit.

Test Plan:
1. Defaults; reset 10 ns, then en=1, mode=0, sat=0 for 10 edges -> qc 1,2,...,7,0,1,2; wrap high only with qc=0.
2. MODULUS=6; mode=1 from qc=0 -> qc 5,4,3,2,1,0,5; wrap with each 5; at_limit high at qc=0.
3. sat=1, mode=0, en=1 from 0 for 10 edges -> qc stops at 7, wrap never asserts, at_limit=1. Then mode=1 -> qc=6 on the next edge.
4. Same edge clr=1, load=1, load_val=3 -> qc=0. Next edge load only, load_val=3 -> qc=3. With MODULUS=6, load_val=7 -> qc=5 and a one-cycle load_err pulse.
5. reset asserted mid-count at qc=4 between edges -> qc=0 immediately with no clock edge; wrap=0 and load_err=0.
6. en=0 for 5 edges at qc=2 with mode toggling -> qc stays 2; at_limit follows the mode/qc rule.
